dms_loop_filter: RTL and testbench

Digital bang-bang loop filter that consumes the `up`/`down` pulse pair produced by the CDR phase-frequency detector and turns it into an unsigned oscillator control word. It sits between the PFD and the DCO/VCO control input in the DMS CDR model. It synchronizes the detector outputs and integrates their votes over fixed windows through a proportional-plus-integral path. It also reports a lock indication.

---
 rtl/dms_loop_filter_if.sv | 20 ++
 rtl/dms_loop_filter.sv | 203 ++++++++++++++++++++
 tb/tb_dms_loop_filter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dms_loop_filter_if.sv
// dms_loop_filter_if: PFD-side inputs and control-word outputs of the loop filter.
//   en       - loop enable (level)
//   up/down  - raw PFD pulses, asynchronous to refclk
//   ctrl     - oscillator control word
//   ctrl_vld - one-cycle strobe marking a ctrl update
//   locked   - lock indication
// master: the side driving the detector signals; slave: the loop filter itself.
interface dms_loop_filter_if #(
    parameter int unsigned CTRL_W = 10
);
    logic              en;
    logic              up;
    logic              down;
    logic [CTRL_W-1:0] ctrl;
    logic              ctrl_vld;
    logic              locked;

    modport master (output en, up, down, input ctrl, ctrl_vld, locked);
    modport slave  (input en, up, down, output ctrl, ctrl_vld, locked);
endinterface

// File: rtl/dms_loop_filter.sv
// dms_loop_filter: bang-bang proportional-plus-integral loop filter for the DMS CDR.
// Synchronizes the PFD up/down pulses, sums their votes over WIN-cycle windows and,
// at each window end, steps the integrator by sign*KI and drives
// ctrl = clamp(mid + integ + sign*KP).
// Ports:
//   refclk - sole clock, rising edge
//   rst_n  - synchronous active-low reset
//   lf     - dms_loop_filter_if.slave (en, up, down in; ctrl, ctrl_vld, locked out)
// Optional feature: define DMS_LF_LOCKDET_EN to build the lock detector; otherwise
// locked is tied to 0 and LOCK_THR/LOCK_WINS have no effect.
module dms_loop_filter #(
    parameter int unsigned WIN       = 16,
    parameter int unsigned KP        = 8,
    parameter int unsigned KI        = 1,
    parameter int unsigned CTRL_W    = 10,
    parameter int unsigned INT_W     = 12,
    parameter int unsigned LOCK_THR  = 2,
    parameter int unsigned LOCK_WINS = 8
) (
    input logic              refclk,
    input logic              rst_n,
    dms_loop_filter_if.slave lf
);
    localparam int unsigned CNT_W = $clog2(WIN);
    localparam int unsigned SUM_W = $clog2(WIN) + 2;
    // Extended width so that integ +/- KI and mid + integ +/- KP never wrap.
    localparam int unsigned EXT_W = INT_W + 2;

    localparam logic signed [EXT_W-1:0] KI_X       = EXT_W'(KI);
    localparam logic signed [EXT_W-1:0] KP_X       = EXT_W'(KP);
    localparam logic signed [EXT_W-1:0] MID_X      = EXT_W'(2 ** (CTRL_W - 1));
    localparam logic signed [EXT_W-1:0] CTRL_MAX_X = EXT_W'(2 ** CTRL_W - 1);
    localparam logic signed [EXT_W-1:0] INT_MAX_X  = EXT_W'(2 ** (INT_W - 1) - 1);
    localparam logic signed [EXT_W-1:0] INT_MIN_X  = -INT_MAX_X - EXT_W'(1);
    localparam logic [CTRL_W-1:0]       CTRL_MID   = {1'b1, {(CTRL_W - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                    state_q, state_d;
    logic                      up_meta_q, up_s_q, down_meta_q, down_s_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic signed [INT_W-1:0]   integ_q, integ_d;
    logic [CTRL_W-1:0]         ctrl_q, ctrl_d;
    logic                      ctrl_vld_q, ctrl_vld_d;

    logic                      step;
    logic                      win_end;
    logic signed [SUM_W-1:0]   v;
    logic signed [SUM_W-1:0]   t;
    logic                      pos, neg;
    logic signed [EXT_W-1:0]   integ_x, integ_sum, integ_sat, ctrl_sum;
    logic [CTRL_W-1:0]         ctrl_new;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            up_meta_q   <= 1'b0;
            up_s_q      <= 1'b0;
            down_meta_q <= 1'b0;
            down_s_q    <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            sum_q       <= '0;
            integ_q     <= '0;
            ctrl_q      <= CTRL_MID;
            ctrl_vld_q  <= 1'b0;
        end else begin
            // Synchronizer runs regardless of en.
            up_meta_q   <= lf.up;
            up_s_q      <= up_meta_q;
            down_meta_q <= lf.down;
            down_s_q    <= down_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            integ_q     <= integ_d;
            ctrl_q      <= ctrl_d;
            ctrl_vld_q  <= ctrl_vld_d;
        end
    end

    // Window arithmetic: t includes the vote of the current cycle.
    always_comb begin
        v = '0;
        if (up_s_q && !down_s_q) begin
            v = SUM_W'(1);
        end else if (down_s_q && !up_s_q) begin
            v = '1;
        end
        t   = sum_q + v;
        neg = t[SUM_W-1];
        pos = !neg && (t != '0);

        integ_x   = {{(EXT_W - INT_W){integ_q[INT_W-1]}}, integ_q};
        integ_sum = integ_x;
        if (pos) begin
            integ_sum = integ_x + KI_X;
        end else if (neg) begin
            integ_sum = integ_x - KI_X;
        end
        integ_sat = integ_sum;
        if (integ_sum > INT_MAX_X) begin
            integ_sat = INT_MAX_X;
        end else if (integ_sum < INT_MIN_X) begin
            integ_sat = INT_MIN_X;
        end

        ctrl_sum = MID_X + integ_sat;
        if (pos) begin
            ctrl_sum = MID_X + integ_sat + KP_X;
        end else if (neg) begin
            ctrl_sum = MID_X + integ_sat - KP_X;
        end
        if (ctrl_sum[EXT_W-1]) begin
            ctrl_new = '0;
        end else if (ctrl_sum > CTRL_MAX_X) begin
            ctrl_new = '1;
        end else begin
            ctrl_new = ctrl_sum[CTRL_W-1:0];
        end
    end

    // IDLE with en=1 already counts as the first cycle of the new window.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        integ_d    = integ_q;
        ctrl_d     = ctrl_q;
        ctrl_vld_d = 1'b0;
        step       = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                sum_d = '0;
                if (lf.en) begin
                    state_d = StRun;
                    step    = 1'b1;
                end
            end
            StRun: begin
                if (!lf.en) begin
                    // Partial window is dropped.
                    state_d = StIdle;
                    cnt_d   = '0;
                    sum_d   = '0;
                end else begin
                    step = 1'b1;
                end
            end
        endcase

        win_end = step && (cnt_q == CNT_W'(WIN - 1));
        if (win_end) begin
            cnt_d      = '0;
            sum_d      = '0;
            integ_d    = integ_sat[INT_W-1:0];
            ctrl_d     = ctrl_new;
            ctrl_vld_d = 1'b1;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            sum_d = t;
        end
    end

`ifdef DMS_LF_LOCKDET_EN
    localparam int unsigned            LCK_W = $clog2(LOCK_WINS + 1);
    localparam logic signed [SUM_W-1:0] THR  = SUM_W'(LOCK_THR);

    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!lf.en) begin
            lock_cnt_d = '0;
        end else if (win_end) begin
            if ((t <= THR) && (t >= -THR)) begin
                if (lock_cnt_q != LCK_W'(LOCK_WINS)) begin
                    lock_cnt_d = lock_cnt_q + LCK_W'(1);
                end
            end else begin
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign lf.locked = (lock_cnt_q == LCK_W'(LOCK_WINS));
`else
    assign lf.locked = 1'b0;
`endif

    assign lf.ctrl     = ctrl_q;
    assign lf.ctrl_vld = ctrl_vld_q;
endmodule

// File: tb/tb_dms_loop_filter.sv
module tb_dms_loop_filter;
    logic refclk = 1'b0;
    logic rst_n;

    always #5 refclk = ~refclk;

    dms_loop_filter_if #(.CTRL_W(10)) lf_if ();

    dms_loop_filter u_dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .lf     (lf_if)
    );

`ifdef DMS_LF_LOCKDET_EN
    localparam logic LOCK_EXP = 1'b1;
`else
    localparam logic LOCK_EXP = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int c, input logic vld, input logic lck);
        chk($sformatf("%s.ctrl", tag), 32'(lf_if.ctrl), c);
        chk($sformatf("%s.vld", tag), 32'(lf_if.ctrl_vld), 32'(vld));
        chk($sformatf("%s.locked", tag), 32'(lf_if.locked), 32'(lck));
    endtask

    task automatic reset_one();
        rst_n     = 1'b0;
        lf_if.en   = 1'b0;
        lf_if.up   = 1'b0;
        lf_if.down = 1'b0;
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        lf_if.en   = 1'b0;
        lf_if.up   = 1'b0;
        lf_if.down = 1'b0;

        // Reset held 3 cycles with up toggling.
        for (int i = 0; i < 3; i++) begin
            lf_if.up = ~lf_if.up;
            tick();
            chk_out("rst", 512, 1'b0, 1'b0);
        end

        // Up dominance: t=14 then 16.
        lf_if.en = 1'b1;
        lf_if.up = 1'b1;
        rst_n    = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("up.vld", 32'(lf_if.ctrl_vld), 32'((k == 16) || (k == 32)));
            if (k == 15) chk("up.w0", 32'(lf_if.ctrl), 512);
            if (k == 16) chk("up.w1", 32'(lf_if.ctrl), 521);
            if (k == 32) chk("up.w2", 32'(lf_if.ctrl), 522);
        end

        // Down dominance.
        reset_one();
        chk_out("rst2", 512, 1'b0, 1'b0);
        lf_if.en   = 1'b1;
        lf_if.down = 1'b1;
        rst_n      = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("dn.vld", 32'(lf_if.ctrl_vld), 32'((k == 16) || (k == 32)));
            if (k == 16) chk("dn.w1", 32'(lf_if.ctrl), 503);
            if (k == 32) chk("dn.w2", 32'(lf_if.ctrl), 502);
        end

        // Balanced votes: lock after 8 quiet windows, then an up-only window drops it.
        reset_one();
        lf_if.en   = 1'b1;
        lf_if.up   = 1'b1;
        lf_if.down = 1'b1;
        rst_n      = 1'b1;
        for (int w = 1; w <= 8; w++) begin
            run(15);
            chk("bal.mid", 32'(lf_if.ctrl_vld), 0);
            chk("bal.premid_lock", 32'(lf_if.locked), 0);
            tick();
            chk_out("bal.end", 512, 1'b1, (w == 8) ? LOCK_EXP : 1'b0);
        end
        lf_if.down = 1'b0;
        run(15);
        chk("lock.hold", 32'(lf_if.locked), 32'(LOCK_EXP));
        tick();
        chk_out("lock.drop", 521, 1'b1, 1'b0);

        // Saturation of ctrl and of the integrator.
        reset_one();
        lf_if.en = 1'b1;
        lf_if.up = 1'b1;
        rst_n    = 1'b1;
        run(502 * 16);
        chk_out("sat.502", 1022, 1'b1, 1'b0);
        run(16);
        chk_out("sat.503", 1023, 1'b1, 1'b0);
        run((2047 - 503) * 16);
        chk_out("sat.2047", 1023, 1'b1, 1'b0);
        run(8 * 16);
        chk_out("sat.hold", 1023, 1'b1, 1'b0);
        lf_if.up   = 1'b0;
        lf_if.down = 1'b1;
        run(1527 * 16);
        chk("desat.520", 32'(lf_if.ctrl), 1023);
        run(16);
        chk("desat.519", 32'(lf_if.ctrl), 1023);
        run(16);
        chk("desat.518", 32'(lf_if.ctrl), 1022);
        run(16);
        chk("desat.517", 32'(lf_if.ctrl), 1021);

        // Enable abort mid-window.
        reset_one();
        lf_if.en = 1'b1;
        lf_if.up = 1'b1;
        rst_n    = 1'b1;
        run(16);
        chk_out("ab.w1", 521, 1'b1, 1'b0);
        run(9);
        lf_if.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out("ab.off", 521, 1'b0, 1'b0);
        end
        lf_if.en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("ab.re_vld", 32'(lf_if.ctrl_vld), 32'(k == 16));
        end
        chk("ab.re_ctrl", 32'(lf_if.ctrl), 522);

        // en falling on the window-end edge suppresses the update.
        run(15);
        lf_if.en = 1'b0;
        tick();
        chk_out("ab.coinc", 522, 1'b0, 1'b0);

        // Reset in the middle of a window.
        lf_if.en = 1'b1;
        run(5);
        rst_n = 1'b0;
        tick();
        chk_out("rst.mid", 512, 1'b0, 1'b0);
        rst_n = 1'b1;
        run(15);
        chk("rst.re_mid", 32'(lf_if.ctrl_vld), 0);
        tick();
        chk_out("rst.re_w1", 521, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
